// File: rtl/display_pkg.sv
// Shared constants and types for the HH.MM seven-segment display path.
// Holds the active-low segment table, clamp limits, the digit index type,
// the conversion FSM state encoding and a digit-to-segment helper.
package display_pkg;

  localparam int HR_MAX  = 23;
  localparam int MIN_MAX = 59;

  // Segment order {g,f,e,d,c,b,a}, active-low (0 lights the segment).
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_LUT [0:9] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

  // Digit slot: 0 = minutes ones, 1 = minutes tens, 2 = hours ones, 3 = hours tens.
  typedef logic [1:0] digit_idx_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CONV_MIN = 2'd1,
    CONV_HR  = 2'd2,
    COMMIT   = 2'd3
  } conv_state_t;

  // Non-decimal nibbles cannot come out of the converter for clamped inputs;
  // they map to a dark digit rather than reading past the table.
  function automatic logic [6:0] seg_of(input logic [3:0] d);
    if (d > 4'd9) begin
      return SEG_BLANK;
    end
    return SEG_LUT[d];
  endfunction

endpackage

// File: rtl/bin2bcd_serial.sv
// Serial double-dabble converter: binary (MSB-aligned in bin) to two BCD
// digits, one shift/add-3 iteration per clock.
// Ports:
//   clk, rst       clock and synchronous active-high reset
//   start          load bin and perform the first iteration this cycle
//   bin[N-1:0]     value to convert, MSB-aligned (the top nbits are used)
//   nbits          number of iterations, i.e. significant bits in bin
//   done           high when the last iteration has completed
//   tens, ones     BCD result (valid while done is high)
module bin2bcd_serial #(
  parameter int N  = 6,
  parameter int CW = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [N-1:0]  bin,
  input  logic [CW-1:0] nbits,
  output logic          done,
  output logic [3:0]    tens,
  output logic [3:0]    ones
);

  logic [7:0]    bcd_reg;
  logic [N-1:0]  sh_reg;
  logic [CW-1:0] cnt_reg;

  logic [7:0]    adj_src;
  logic [N-1:0]  sh_src;
  logic [7:0]    adj;
  logic [7:0]    bcd_next;
  logic [N-1:0]  sh_next;
  logic          unused_adj_msb;

  // The start cycle iterates straight from bin with an empty BCD register,
  // so a field of k bits takes exactly k clocks including the start cycle.
  always_comb begin
    adj_src = bcd_reg;
    sh_src  = sh_reg;
    if (start) begin
      adj_src = 8'd0;
      sh_src  = bin;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_adj
      assign adj[gi*4 +: 4] = (adj_src[gi*4 +: 4] >= 4'd5) ?
                              adj_src[gi*4 +: 4] + 4'd3 : adj_src[gi*4 +: 4];
    end
  endgenerate

  // Results never exceed 99, so the top adjusted bit always shifts out as 0.
  assign unused_adj_msb = adj[7];
  assign bcd_next       = {adj[6:0], sh_src[N-1]};
  assign sh_next        = {sh_src[N-2:0], 1'b0};

  always_ff @(posedge clk) begin
    if (rst) begin
      bcd_reg <= 8'd0;
      sh_reg  <= '0;
      cnt_reg <= '0;
    end else if (start) begin
      bcd_reg <= bcd_next;
      sh_reg  <= sh_next;
      cnt_reg <= nbits - CW'(1);
    end else if (cnt_reg != '0) begin
      bcd_reg <= bcd_next;
      sh_reg  <= sh_next;
      cnt_reg <= cnt_reg - CW'(1);
    end
  end

  assign done = (cnt_reg == '0);
  assign tens = bcd_reg[7:4];
  assign ones = bcd_reg[3:0];

endmodule

// File: rtl/time_display_scan.sv
// HH.MM display driver for the four Basys3 seven-segment digits.
// Captures clamped binary hours/minutes on load, converts them to BCD with a
// single shared serial converter, commits all four digits at once and scans
// them onto the anodes.
// Ports:
//   clk, rst     100 MHz clock, synchronous active-high reset
//   load         one-cycle capture strobe for hours/minutes
//   hours        binary hours (0..23 valid, larger clamps to 23)
//   minutes      binary minutes (0..59 valid, larger clamps to 59)
//   blank        force all anodes off; scanning keeps running
//   busy         conversion in progress
//   an[3:0]      anodes, active-low, an[0] = minutes ones
//   seg[6:0]     segments {g,f,e,d,c,b,a}, active-low
//   dp           decimal point, active-low, lit on the hours-ones digit
module time_display_scan
  import display_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int HR_BITS     = 5,
  parameter int MIN_BITS    = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [HR_BITS-1:0]  hours,
  input  logic [MIN_BITS-1:0] minutes,
  input  logic                blank,
  output logic                busy,
  output logic [3:0]          an,
  output logic [6:0]          seg,
  output logic                dp
);

  localparam int CONV_BITS = (MIN_BITS > HR_BITS) ? MIN_BITS : HR_BITS;
  localparam int CW        = $clog2(CONV_BITS + 1);
  localparam int RW        = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  // Input clamping
  logic [HR_BITS-1:0]  hr_clamped;
  logic [MIN_BITS-1:0] min_clamped;

  assign hr_clamped  = (32'(hours)   > HR_MAX)  ? HR_BITS'(HR_MAX)   : hours;
  assign min_clamped = (32'(minutes) > MIN_MAX) ? MIN_BITS'(MIN_MAX) : minutes;

  // Capture / pending state
  conv_state_t         state_reg, state_next;
  logic [CW-1:0]       step_reg, step_next;
  logic [HR_BITS-1:0]  cap_hr_reg, pend_hr_reg;
  logic [MIN_BITS-1:0] cap_min_reg, pend_min_reg;
  logic                pend_reg;
  logic [3:0]          min_tens_reg, min_ones_reg;
  logic [15:0]         disp_reg;

  logic                capture_in;
  logic                capture_pend;
  logic                pend_set;
  logic                latch_min;
  logic                commit;
  logic                commit_now;

  // Converter interface
  logic                conv_start;
  logic [CONV_BITS-1:0] conv_bin;
  logic [CW-1:0]       conv_nbits;
  logic                conv_done;
  logic [3:0]          conv_tens, conv_ones;
  logic [CONV_BITS-1:0] min_aligned, hr_aligned;

  // Fields are MSB-aligned so the converter only runs as many iterations as
  // the field has bits.
  assign min_aligned = CONV_BITS'(cap_min_reg) << (CONV_BITS - MIN_BITS);
  assign hr_aligned  = CONV_BITS'(cap_hr_reg)  << (CONV_BITS - HR_BITS);

  bin2bcd_serial #(
    .N  (CONV_BITS),
    .CW (CW)
  ) u_bcd (
    .clk   (clk),
    .rst   (rst),
    .start (conv_start),
    .bin   (conv_bin),
    .nbits (conv_nbits),
    .done  (conv_done),
    .tens  (conv_tens),
    .ones  (conv_ones)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      step_reg  <= '0;
    end else begin
      state_reg <= state_next;
      step_reg  <= step_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    step_next    = step_reg;
    conv_start   = 1'b0;
    conv_bin     = min_aligned;
    conv_nbits   = CW'(MIN_BITS);
    capture_in   = 1'b0;
    capture_pend = 1'b0;
    pend_set     = 1'b0;
    latch_min    = 1'b0;
    commit       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (load) begin
          capture_in = 1'b1;
          state_next = CONV_MIN;
          step_next  = '0;
        end
      end
      CONV_MIN: begin
        conv_start = (step_reg == '0);
        pend_set   = load;
        if (step_reg == CW'(MIN_BITS - 1)) begin
          state_next = CONV_HR;
          step_next  = '0;
        end else begin
          step_next  = step_reg + CW'(1);
        end
      end
      CONV_HR: begin
        // The converter still holds the minutes result on the first cycle
        // here; save it before the hours conversion overwrites it.
        conv_start = (step_reg == '0);
        latch_min  = (step_reg == '0);
        conv_bin   = hr_aligned;
        conv_nbits = CW'(HR_BITS);
        pend_set   = load;
        if (step_reg == CW'(HR_BITS - 1)) begin
          state_next = COMMIT;
          step_next  = '0;
        end else begin
          step_next  = step_reg + CW'(1);
        end
      end
      COMMIT: begin
        commit = 1'b1;
        // A load arriving now is the newest value, so it supersedes any
        // older pending entry and starts converting immediately.
        if (load) begin
          capture_in = 1'b1;
          state_next = CONV_MIN;
        end else if (pend_reg) begin
          capture_pend = 1'b1;
          state_next   = CONV_MIN;
        end else begin
          state_next   = IDLE;
        end
        step_next = '0;
      end
      default: begin
        state_next = IDLE;
        step_next  = '0;
      end
    endcase
  end

  assign commit_now = commit && conv_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      cap_hr_reg   <= '0;
      cap_min_reg  <= '0;
      pend_hr_reg  <= '0;
      pend_min_reg <= '0;
      pend_reg     <= 1'b0;
      min_tens_reg <= 4'd0;
      min_ones_reg <= 4'd0;
      disp_reg     <= 16'd0;
    end else begin
      if (capture_in) begin
        cap_hr_reg  <= hr_clamped;
        cap_min_reg <= min_clamped;
      end else if (capture_pend) begin
        cap_hr_reg  <= pend_hr_reg;
        cap_min_reg <= pend_min_reg;
      end
      if (pend_set) begin
        pend_hr_reg  <= hr_clamped;
        pend_min_reg <= min_clamped;
        pend_reg     <= 1'b1;
      end else if (capture_in || capture_pend) begin
        pend_reg     <= 1'b0;
      end
      if (latch_min) begin
        min_tens_reg <= conv_tens;
        min_ones_reg <= conv_ones;
      end
      if (commit_now) begin
        disp_reg <= {conv_tens, conv_ones, min_tens_reg, min_ones_reg};
      end
    end
  end

  assign busy = (state_reg != IDLE);

  // Scan
  logic [RW-1:0] ref_cnt_reg;
  digit_idx_t    idx_reg;
  logic [3:0]    an_reg;
  logic [6:0]    seg_reg;
  logic          dp_reg;
  logic [15:0]   disp_view;
  logic [6:0]    digit_seg;
  logic [3:0]    an_next;

  // On the commit cycle the segment register takes the freshly converted
  // digits directly, so new values appear the cycle after COMMIT instead of
  // one later.
  always_comb begin
    disp_view = disp_reg;
    if (commit_now) begin
      disp_view = {conv_tens, conv_ones, min_tens_reg, min_ones_reg};
    end
    digit_seg = SEG_BLANK;
    case (idx_reg)
      2'd0:    digit_seg = seg_of(disp_view[3:0]);
      2'd1:    digit_seg = seg_of(disp_view[7:4]);
      2'd2:    digit_seg = seg_of(disp_view[11:8]);
      default: digit_seg = (disp_view[15:12] == 4'd0) ? SEG_BLANK
                                                      : seg_of(disp_view[15:12]);
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_an
      assign an_next[gi] = blank || (idx_reg != digit_idx_t'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      ref_cnt_reg <= '0;
      idx_reg     <= 2'd0;
      an_reg      <= 4'b1111;
      seg_reg     <= SEG_BLANK;
      dp_reg      <= 1'b1;
    end else begin
      if (ref_cnt_reg == RW'(REFRESH_DIV - 1)) begin
        ref_cnt_reg <= '0;
        idx_reg     <= idx_reg + 2'd1;
      end else begin
        ref_cnt_reg <= ref_cnt_reg + RW'(1);
      end
      an_reg  <= an_next;
      seg_reg <= digit_seg;
      dp_reg  <= (idx_reg != 2'd2);
    end
  end

  assign an  = an_reg;
  assign seg = seg_reg;
  assign dp  = dp_reg;

endmodule
